// File: rtl/ex_muldiv_pkg.sv
// Shared constants, op encodings and FSM states for the EX-stage iterative multiply/divide unit.
package ex_muldiv_pkg;
  localparam int unsigned XLEN = 64;
  localparam int unsigned ITER = 64;
  localparam int unsigned CNTW = 7;
  localparam int unsigned RDW  = 5;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_UDIV = 2'b01;
  localparam logic [1:0] OP_SDIV = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module muldiv_iter
  import ex_muldiv_pkg::*;
(
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] x_nxt,
  output logic [XLEN-1:0] y_nxt
);

  logic [XLEN:0] sh_c;
  logic          ge_c;

  // Divide: remainder stays below the divisor, so the shifted value fits in XLEN+1 bits.
  assign sh_c = {acc, y[XLEN-1]};
  assign ge_c = (sh_c >= {1'b0, x});

  always_comb begin
    acc_nxt = acc;
    x_nxt   = x;
    y_nxt   = y;
    if (is_div) begin
      acc_nxt = ge_c ? (sh_c[XLEN-1:0] - x) : sh_c[XLEN-1:0];
      y_nxt   = {y[XLEN-2:0], ge_c};
    end else begin
      acc_nxt = acc + (y[0] ? x : '0);
      x_nxt   = {x[XLEN-2:0], 1'b0};
      y_nxt   = {1'b0, y[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle MUL/UDIV/SDIV unit: stalls the front of the pipe for 64 iterations
// and returns the low product half or the quotient with its captured destination tag.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start_In,
  input  logic [1:0]      op_In,
  input  logic [XLEN-1:0] rd_data_1_In,
  input  logic [XLEN-1:0] rd_data_2_In,
  input  logic [RDW-1:0]  RegisterRd_In,
  input  logic            flush_In,
  output logic            stall_Out,
  output logic            done_Out,
  output logic [XLEN-1:0] result_Out,
  output logic [RDW-1:0]  RegisterRd_Out,
  output logic            div_zero_Out
);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] acc_q, x_q, y_q;
  logic [RDW-1:0]  rd_q;
  logic            neg_q, dz_q;

  logic            accept_c, iter_c, last_c, finish_c;
  logic            is_div_c, div_in_c, sdiv_in_c, a_neg_c, b_neg_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c, quo_fix_c;
  logic [XLEN-1:0] acc_nxt, x_nxt, y_nxt;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and control; flush outranks any start seen while busy or done.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    iter_c   = 1'b0;
    last_c   = 1'b0;
    finish_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_In && (op_In != OP_RSVD) && !flush_In) begin
          accept_c = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (flush_In) begin
          state_d = IDLE;
        end else begin
          iter_c = 1'b1;
          if (cnt_q == CNTW'(ITER - 1)) begin
            last_c  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        finish_c = !flush_In;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_Out = accept_c | (state_q == BUSY);

  // Operand conditioning at capture: signed divide works on magnitudes.
  assign sdiv_in_c = (op_In == OP_SDIV);
  assign div_in_c  = (op_In == OP_UDIV) || sdiv_in_c;
  assign a_neg_c   = sdiv_in_c & rd_data_1_In[XLEN-1];
  assign b_neg_c   = sdiv_in_c & rd_data_2_In[XLEN-1];
  assign a_mag_c   = a_neg_c ? XLEN'(-rd_data_1_In) : rd_data_1_In;
  assign b_mag_c   = b_neg_c ? XLEN'(-rd_data_2_In) : rd_data_2_In;

  assign is_div_c  = (op_q == OP_UDIV) || (op_q == OP_SDIV);
  assign quo_fix_c = dz_q ? '0 : (neg_q ? XLEN'(-y_nxt) : y_nxt);

  muldiv_iter u_iter (
    .is_div  (is_div_c),
    .acc     (acc_q),
    .x       (x_q),
    .y       (y_q),
    .acc_nxt (acc_nxt),
    .x_nxt   (x_nxt),
    .y_nxt   (y_nxt)
  );

  // Operand/accumulator registers; the last divide step stores the sign-fixed quotient.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= OP_MUL;
      acc_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      rd_q  <= '0;
      neg_q <= 1'b0;
      dz_q  <= 1'b0;
    end else if (accept_c) begin
      cnt_q <= '0;
      op_q  <= op_In;
      acc_q <= '0;
      x_q   <= div_in_c ? b_mag_c : rd_data_1_In;
      y_q   <= div_in_c ? a_mag_c : rd_data_2_In;
      rd_q  <= RegisterRd_In;
      neg_q <= a_neg_c ^ b_neg_c;
      dz_q  <= div_in_c && (rd_data_2_In == '0);
    end else if (iter_c) begin
      cnt_q <= cnt_q + CNTW'(1);
      acc_q <= acc_nxt;
      x_q   <= x_nxt;
      y_q   <= (last_c && is_div_c) ? quo_fix_c : y_nxt;
    end
  end

  // Result registers change only when a completed op leaves DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_Out       <= 1'b0;
      result_Out     <= '0;
      RegisterRd_Out <= '0;
      div_zero_Out   <= 1'b0;
    end else begin
      done_Out <= finish_c;
      if (finish_c) begin
        result_Out     <= is_div_c ? y_q : acc_q;
        RegisterRd_Out <= rd_q;
        div_zero_Out   <= dz_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: vector table, random ops and abort/ignore sequences.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            start_In;
  logic [1:0]      op_In;
  logic [63:0]     rd_data_1_In, rd_data_2_In;
  logic [4:0]      RegisterRd_In;
  logic            flush_In;
  logic            stall_Out, done_Out, div_zero_Out;
  logic [63:0]     result_Out;
  logic [4:0]      RegisterRd_Out;

  ex_muldiv dut (
    .clk            (clk),
    .reset          (reset),
    .start_In       (start_In),
    .op_In          (op_In),
    .rd_data_1_In   (rd_data_1_In),
    .rd_data_2_In   (rd_data_2_In),
    .RegisterRd_In  (RegisterRd_In),
    .flush_In       (flush_In),
    .stall_Out      (stall_Out),
    .done_Out       (done_Out),
    .result_Out     (result_Out),
    .RegisterRd_Out (RegisterRd_Out),
    .div_zero_Out   (div_zero_Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] er;
    logic        edz;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        dz;
  } exp_t;

  exp_t        sq[$];
  vec_t        vt[10];
  int          passed = 0;
  int          total  = 0;
  logic [63:0] last_res = '0;
  logic [4:0]  last_rd  = '0;
  logic        last_dz  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    if (op == 2'b00)        model = a * b;
    else if (b == '0)       model = '0;
    else if (op == 2'b01)   model = a / b;
    else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) model = a;
    else                    model = 64'(sa / sb);
  endfunction

  task automatic quiet(input int cycles, input string nm);
    int dn;
    dn = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done_Out) dn++;
    end
    chk({nm, "_no_done"}, 64'(dn), 64'd0);
  endtask

  // Issue one op; optionally poke start, flush or reset at a given BUSY cycle (-1 = never).
  task automatic run(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] rd, input logic [63:0] er, input logic edz,
                     input int poke_at, input int flush_at, input int reset_at, input string nm);
    int   n, stall_n, abort_at;
    exp_t e;
    abort_at = (flush_at >= 0) ? flush_at : reset_at;
    @(posedge clk); #1;
    sq.push_back('{res: er, rd: rd, dz: edz});
    start_In = 1'b1; op_In = op; rd_data_1_In = a; rd_data_2_In = b; RegisterRd_In = rd;
    #1;
    stall_n = stall_Out ? 1 : 0;
    @(posedge clk); #1;
    start_In = 1'b0;
    rd_data_1_In = {$urandom, $urandom};
    rd_data_2_In = {$urandom, $urandom};
    RegisterRd_In = 5'($urandom);
    n = 0;
    while (!done_Out && n < 200) begin
      if (stall_Out) stall_n++;
      if (n == poke_at) begin start_In = 1'b1; op_In = OP_UDIV; RegisterRd_In = ~rd; end
      if (n == flush_at) flush_In = 1'b1;
      if (n == reset_at) reset = 1'b1;
      @(posedge clk); #1;
      start_In = 1'b0; flush_In = 1'b0; reset = 1'b0;
      n++;
      if (abort_at >= 0 && n == abort_at + 1) break;
    end
    if (abort_at >= 0) begin
      sq.delete();
      if (reset_at >= 0) begin
        last_res = '0; last_rd = '0; last_dz = 1'b0;
      end
      chk({nm, "_abort_done"},  64'(done_Out), 64'd0);
      chk({nm, "_abort_stall"}, 64'(stall_Out), 64'd0);
      chk({nm, "_abort_res"},   result_Out, last_res);
      chk({nm, "_abort_rd"},    64'(RegisterRd_Out), 64'(last_rd));
      chk({nm, "_abort_dz"},    64'(div_zero_Out), 64'(last_dz));
    end else begin
      chk({nm, "_latency"}, 64'(n), 64'd65);
      chk({nm, "_stall_cycles"}, 64'(stall_n), 64'd65);
      if (sq.size() == 0) begin
        chk({nm, "_sb_empty"}, 64'(sq.size()), 64'd1);
      end else begin
        e = sq.pop_front();
        chk({nm, "_result"}, result_Out, e.res);
        chk({nm, "_rd"},     64'(RegisterRd_Out), 64'(e.rd));
        chk({nm, "_dz"},     64'(div_zero_Out), 64'(e.dz));
        last_res = e.res; last_rd = e.rd; last_dz = e.dz;
      end
      @(posedge clk); #1;
      chk({nm, "_done_pulse"}, 64'(done_Out), 64'd0);
      chk({nm, "_hold"}, result_Out, last_res);
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [63:0] ra, rb;

    vt[0] = '{2'b00, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
    vt[1] = '{2'b01, 64'd100, 64'd7, 5'd9, 64'd14, 1'b0};
    vt[2] = '{2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd10, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};
    vt[3] = '{2'b01, 64'd5, 64'd0, 5'd11, 64'd0, 1'b1};
    vt[4] = '{2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 64'h8000_0000_0000_0000, 1'b0};
    vt[5] = '{2'b10, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd13, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};
    vt[6] = '{2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 5'd14, 64'd14, 1'b0};
    vt[7] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 64'd1, 1'b0};
    vt[8] = '{2'b10, 64'd5, 64'd0, 5'd3, 64'd0, 1'b1};
    vt[9] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0};

    reset = 1'b1; start_In = 1'b0; flush_In = 1'b0; op_In = 2'b00;
    rd_data_1_In = '0; rd_data_2_In = '0; RegisterRd_In = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_done",  64'(done_Out), 64'd0);
    chk("reset_res",   result_Out, 64'd0);
    chk("reset_rd",    64'(RegisterRd_Out), 64'd0);
    chk("reset_dz",    64'(div_zero_Out), 64'd0);
    chk("reset_stall", 64'(stall_Out), 64'd0);

    for (int i = 0; i < 10; i++)
      run(vt[i].op, vt[i].a, vt[i].b, vt[i].rd, vt[i].er, vt[i].edz, -1, -1, -1, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rop = 2'(i % 3);
      ra  = {$urandom, $urandom};
      rb  = (i % 2 == 1) ? {32'h0, $urandom} : {$urandom, $urandom};
      run(rop, ra, rb, 5'(i + 16), model(rop, ra, rb), (rop != 2'b00) && (rb == '0),
          -1, -1, -1, $sformatf("rnd%0d", i));
    end

    // start during BUSY is dropped, not queued
    run(2'b00, 64'd123456789, 64'd987654321, 5'd21, model(2'b00, 64'd123456789, 64'd987654321), 1'b0,
        30, -1, -1, "poke30");
    quiet(70, "poke30");

    // reserved op: no stall, no completion
    @(posedge clk); #1;
    start_In = 1'b1; op_In = OP_RSVD; rd_data_1_In = 64'd9; rd_data_2_In = 64'd3;
    #1;
    chk("rsvd_stall", 64'(stall_Out), 64'd0);
    @(posedge clk); #1;
    start_In = 1'b0;
    chk("rsvd_idle_stall", 64'(stall_Out), 64'd0);
    quiet(70, "rsvd");

    // flush mid-op, then a fresh op right behind it
    run(2'b01, 64'd1000, 64'd3, 5'd22, 64'd333, 1'b0, -1, 40, -1, "flush40");
    run(2'b10, 64'hFFFF_FFFF_FFFF_FC18, 64'd3, 5'd23, 64'hFFFF_FFFF_FFFF_FEB3, 1'b0, -1, -1, -1, "after_flush");

    // reset mid-op clears outputs, then normal operation resumes
    run(2'b00, 64'd11, 64'd13, 5'd24, 64'd143, 1'b0, -1, -1, 10, "reset10");
    quiet(70, "reset10");
    run(2'b01, 64'd77, 64'd10, 5'd25, 64'd7, 1'b0, -1, -1, -1, "after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
